// File: rtl/sram_bank_ctrl.sv
// sram_bank_ctrl: multi-bank controller for dual-port OpenRAM-style SRAM macros.
// dbus (LSU) owns port 0 (read/write) of every bank, ibus (fetch) owns port 1
// (read-only). An ibus fetch of the word dbus is writing in the same cycle is
// stalled. Requests decoding to a bank >= NUM_BANKS get an error response.
// Optional build macro SRAM_RDATA_REG_EN registers read data, giving a
// two-cycle response latency instead of one.
module sram_bank_ctrl #(
  parameter int unsigned NUM_BANKS  = 8,
  parameter int unsigned NUM_WMASKS = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  // data bus slave
  input  logic                             dbus_req_i,
  output logic                             dbus_gnt_o,
  input  logic                             dbus_we_i,
  input  logic [NUM_WMASKS-1:0]            dbus_be_i,
  input  logic [31:0]                      dbus_addr_i,
  input  logic [DATA_WIDTH-1:0]            dbus_wdata_i,
  output logic                             dbus_rvalid_o,
  output logic [DATA_WIDTH-1:0]            dbus_rdata_o,
  output logic                             dbus_err_o,
  // instruction bus slave (we/be/wdata ignored)
  input  logic                             ibus_req_i,
  output logic                             ibus_gnt_o,
  input  logic                             ibus_we_i,
  input  logic [NUM_WMASKS-1:0]            ibus_be_i,
  input  logic [31:0]                      ibus_addr_i,
  input  logic [DATA_WIDTH-1:0]            ibus_wdata_i,
  output logic                             ibus_rvalid_o,
  output logic [DATA_WIDTH-1:0]            ibus_rdata_o,
  output logic                             ibus_err_o,
  // SRAM port 0
  output logic [NUM_BANKS-1:0]             sram_clk0_o,
  output logic [NUM_BANKS-1:0]             sram_csb0_o,
  output logic [NUM_BANKS-1:0]             sram_web0_o,
  output logic [NUM_BANKS*NUM_WMASKS-1:0]  sram_wmask0_o,
  output logic [NUM_BANKS*ADDR_WIDTH-1:0]  sram_addr0_o,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]  sram_din0_o,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]  sram_dout0_i,
  // SRAM port 1
  output logic [NUM_BANKS-1:0]             sram_clk1_o,
  output logic [NUM_BANKS-1:0]             sram_csb1_o,
  output logic [NUM_BANKS*ADDR_WIDTH-1:0]  sram_addr1_o,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]  sram_dout1_i
);

  localparam int unsigned BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned BANK_LSB  = ADDR_WIDTH + 2;
  localparam int unsigned BANK_MSB  = ADDR_WIDTH + BANK_BITS + 1;
  localparam logic [BANK_BITS:0] BANK_LIMIT = (BANK_BITS+1)'(NUM_BANKS);

  logic [BANK_BITS-1:0]  d_bank, i_bank;
  logic [ADDR_WIDTH-1:0] d_word, i_word;
  logic                  d_oor, i_oor;
  logic                  hazard;
  logic                  d_gnt, i_gnt;
  logic                  d_acc, i_acc;

  logic                  d_rvalid_q, d_rvalid_d, i_rvalid_q, i_rvalid_d;
  logic                  d_err_q, d_err_d, i_err_q, i_err_d;
  logic [BANK_BITS-1:0]  d_bank_q, d_bank_d, i_bank_q, i_bank_d;

  logic [NUM_BANKS*DATA_WIDTH-1:0] d_masked, i_masked;
  logic [DATA_WIDTH-1:0]           d_mux, i_mux;

  // Address decode: word and bank fields, range check against NUM_BANKS
  always_comb begin
    d_word = dbus_addr_i[ADDR_WIDTH+1:2];
    i_word = ibus_addr_i[ADDR_WIDTH+1:2];
    d_bank = dbus_addr_i[BANK_MSB:BANK_LSB];
    i_bank = ibus_addr_i[BANK_MSB:BANK_LSB];
    d_oor  = ({1'b0, d_bank} >= BANK_LIMIT);
    i_oor  = ({1'b0, i_bank} >= BANK_LIMIT);
  end

  // Grant: dbus never stalls; ibus waits while dbus writes the same word.
  // Nothing is granted while reset is held so the macros stay deselected.
  always_comb begin
    hazard = dbus_req_i & dbus_we_i & ibus_req_i & ~d_oor & ~i_oor &
             (d_bank == i_bank) & (d_word == i_word);
    d_gnt  = dbus_req_i & rst_ni;
    i_gnt  = ibus_req_i & rst_ni & ~hazard;
    d_acc  = d_gnt & ~d_oor;
    i_acc  = i_gnt & ~i_oor;
  end

  assign dbus_gnt_o  = d_gnt;
  assign ibus_gnt_o  = i_gnt;
  assign sram_clk0_o = {NUM_BANKS{clk_i}};
  assign sram_clk1_o = {NUM_BANKS{clk_i}};

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic sel0, sel1;
    assign sel0 = d_acc & (d_bank == BANK_BITS'(b));
    assign sel1 = i_acc & (i_bank == BANK_BITS'(b));

    assign sram_csb0_o[b] = ~sel0;
    assign sram_web0_o[b] = ~(sel0 & dbus_we_i);
    assign sram_wmask0_o[b*NUM_WMASKS +: NUM_WMASKS] = sel0 ? dbus_be_i    : '0;
    assign sram_addr0_o[b*ADDR_WIDTH +: ADDR_WIDTH]  = sel0 ? d_word       : '0;
    assign sram_din0_o[b*DATA_WIDTH +: DATA_WIDTH]   = sel0 ? dbus_wdata_i : '0;

    assign sram_csb1_o[b] = ~sel1;
    assign sram_addr1_o[b*ADDR_WIDTH +: ADDR_WIDTH]  = sel1 ? i_word : '0;

    // Per-bank read data gated by the registered bank, OR-reduced below
    assign d_masked[b*DATA_WIDTH +: DATA_WIDTH] =
      (d_bank_q == BANK_BITS'(b)) ? sram_dout0_i[b*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign i_masked[b*DATA_WIDTH +: DATA_WIDTH] =
      (i_bank_q == BANK_BITS'(b)) ? sram_dout1_i[b*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  // Read-data mux: OR of the masked bank outputs (zero when bank_q is out of range)
  always_comb begin
    d_mux = '0;
    i_mux = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      d_mux |= d_masked[b*DATA_WIDTH +: DATA_WIDTH];
      i_mux |= i_masked[b*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Response stage 1 next state: one response per granted request
  always_comb begin
    d_rvalid_d = d_gnt;
    d_err_d    = d_gnt & d_oor;
    d_bank_d   = d_bank;
    i_rvalid_d = i_gnt;
    i_err_d    = i_gnt & i_oor;
    i_bank_d   = i_bank;
  end

  // Response stage 1 registers; reset drops any outstanding response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      d_bank_q   <= '0;
      i_rvalid_q <= 1'b0;
      i_err_q    <= 1'b0;
      i_bank_q   <= '0;
    end else begin
      d_rvalid_q <= d_rvalid_d;
      d_err_q    <= d_err_d;
      d_bank_q   <= d_bank_d;
      i_rvalid_q <= i_rvalid_d;
      i_err_q    <= i_err_d;
      i_bank_q   <= i_bank_d;
    end
  end

`ifdef SRAM_RDATA_REG_EN
  logic                  d_rvalid2_q, d_rvalid2_d, i_rvalid2_q, i_rvalid2_d;
  logic                  d_err2_q, d_err2_d, i_err2_q, i_err2_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d, i_rdata_q, i_rdata_d;

  // Output stage next state: capture macro data while it is valid
  always_comb begin
    d_rvalid2_d = d_rvalid_q;
    d_err2_d    = d_err_q;
    d_rdata_d   = d_err_q ? '0 : d_mux;
    i_rvalid2_d = i_rvalid_q;
    i_err2_d    = i_err_q;
    i_rdata_d   = i_err_q ? '0 : i_mux;
  end

  // Output stage registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_rvalid2_q <= 1'b0;
      d_err2_q    <= 1'b0;
      d_rdata_q   <= '0;
      i_rvalid2_q <= 1'b0;
      i_err2_q    <= 1'b0;
      i_rdata_q   <= '0;
    end else begin
      d_rvalid2_q <= d_rvalid2_d;
      d_err2_q    <= d_err2_d;
      d_rdata_q   <= d_rdata_d;
      i_rvalid2_q <= i_rvalid2_d;
      i_err2_q    <= i_err2_d;
      i_rdata_q   <= i_rdata_d;
    end
  end

  assign dbus_rvalid_o = d_rvalid2_q;
  assign dbus_err_o    = d_err2_q;
  assign dbus_rdata_o  = d_rdata_q;
  assign ibus_rvalid_o = i_rvalid2_q;
  assign ibus_err_o    = i_err2_q;
  assign ibus_rdata_o  = i_rdata_q;
`else
  assign dbus_rvalid_o = d_rvalid_q;
  assign dbus_err_o    = d_err_q;
  assign dbus_rdata_o  = d_err_q ? '0 : d_mux;
  assign ibus_rvalid_o = i_rvalid_q;
  assign ibus_err_o    = i_err_q;
  assign ibus_rdata_o  = i_err_q ? '0 : i_mux;
`endif

  // Address bits outside the decoded fields and the ibus write fields are ignored
  logic unused_ok;
  assign unused_ok = ^{ibus_we_i, ibus_be_i, ibus_wdata_i,
                       dbus_addr_i[31:BANK_MSB+1], dbus_addr_i[1:0],
                       ibus_addr_i[31:BANK_MSB+1], ibus_addr_i[1:0]};

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Bench for sram_bank_ctrl with six banks (banks 6 and 7 decode out of range).
// Memory contents are predicted by a flat word-indexed reference store; bus
// responses are predicted per cycle from the decode/grant/hazard rules.
module tb_sram_bank_ctrl;
  localparam int unsigned NB = 6;
  localparam int unsigned NW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 9;
`ifdef SRAM_RDATA_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk, rst_ni;
  logic dreq, dgnt, dwe, drvalid, derr;
  logic [NW-1:0] dbe;
  logic [31:0] daddr;
  logic [DW-1:0] dwdata, drdata;
  logic ireq, ignt, iwe, irvalid, ierr;
  logic [NW-1:0] ibe;
  logic [31:0] iaddr;
  logic [DW-1:0] iwdata, irdata;
  logic [NB-1:0] clk0, csb0, web0, clk1, csb1;
  logic [NB*NW-1:0] wmask0;
  logic [NB*AW-1:0] addr0, addr1;
  logic [NB*DW-1:0] din0, dout0, dout1;

  sram_bank_ctrl #(.NUM_BANKS(NB), .NUM_WMASKS(NW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .dbus_req_i(dreq), .dbus_gnt_o(dgnt), .dbus_we_i(dwe), .dbus_be_i(dbe),
    .dbus_addr_i(daddr), .dbus_wdata_i(dwdata), .dbus_rvalid_o(drvalid),
    .dbus_rdata_o(drdata), .dbus_err_o(derr),
    .ibus_req_i(ireq), .ibus_gnt_o(ignt), .ibus_we_i(iwe), .ibus_be_i(ibe),
    .ibus_addr_i(iaddr), .ibus_wdata_i(iwdata), .ibus_rvalid_o(irvalid),
    .ibus_rdata_o(irdata), .ibus_err_o(ierr),
    .sram_clk0_o(clk0), .sram_csb0_o(csb0), .sram_web0_o(web0), .sram_wmask0_o(wmask0),
    .sram_addr0_o(addr0), .sram_din0_o(din0), .sram_dout0_i(dout0),
    .sram_clk1_o(clk1), .sram_csb1_o(csb1), .sram_addr1_o(addr1), .sram_dout1_i(dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(int unsigned b, int unsigned w);
    return 32'h5A00_0000 + b * 32'h0001_0000 + w * 32'd3;
  endfunction

  // Behavioural dual-port macros: synchronous read, byte-masked write
  logic [DW-1:0] mem [NB][1<<AW];
  initial
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < (1 << AW); w++) mem[b][w] = init_val(b, w);

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (!csb0[b]) begin
        if (!web0[b]) begin
          for (int l = 0; l < NW; l++)
            if (wmask0[b*NW+l]) mem[b][addr0[b*AW +: AW]][l*8 +: 8] <= din0[b*DW + l*8 +: 8];
        end else begin
          dout0[b*DW +: DW] <= mem[b][addr0[b*AW +: AW]];
        end
      end
      if (!csb1[b]) dout1[b*DW +: DW] <= mem[b][addr1[b*AW +: AW]];
    end
  end

  // Reference store: one entry per (bank, word) written so far
  logic [DW-1:0] ref_mem [int unsigned];
  function automatic logic [DW-1:0] ref_rd(int unsigned b, int unsigned w);
    int unsigned k = b * 512 + w;
    return ref_mem.exists(k) ? ref_mem[k] : init_val(b, w);
  endfunction

  typedef struct packed { logic v; logic e; logic chk; logic [DW-1:0] d; } resp_t;
  resp_t dq[$], iq[$];

  int n_tests = 0;
  int n_fail = 0;
  logic last_ig;
  logic obs_dgnt, obs_ignt, obs_drv, obs_derr, obs_irv, obs_ierr;
  logic [NB-1:0] obs_csb0, obs_csb1, obs_web0;
  logic [NB*AW-1:0] obs_a0;
  logic [DW-1:0] obs_drd, obs_ird;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_d_rvalid"}, drvalid, 1'b0);
    check({tag, "_i_rvalid"}, irvalid, 1'b0);
    check({tag, "_d_err"}, derr, 1'b0);
    check({tag, "_i_err"}, ierr, 1'b0);
    check({tag, "_csb0"}, csb0, {NB{1'b1}});
    check({tag, "_csb1"}, csb1, {NB{1'b1}});
    check({tag, "_web0"}, web0, {NB{1'b1}});
  endtask

  // One bus cycle: drive, check combinational outputs and due responses, predict, advance
  task automatic step(input logic d_r, input logic d_w, input logic [NW-1:0] d_be,
                      input logic [31:0] d_a, input logic [DW-1:0] d_wd,
                      input logic i_r, input logic [31:0] i_a);
    int unsigned db, ib, dw, iw;
    logic door, ioor, haz, ig;
    logic [NB-1:0] e_csb0, e_web0, e_csb1;
    logic [NB*NW-1:0] e_wm;
    logic [NB*AW-1:0] e_a0, e_a1;
    logic [NB*DW-1:0] e_din;
    resp_t de, ie, dn, inx;
    logic [DW-1:0] old;
    dreq = d_r; dwe = d_w; dbe = d_be; daddr = d_a; dwdata = d_wd;
    ireq = i_r; iaddr = i_a; iwe = 1'($urandom); ibe = NW'($urandom); iwdata = $urandom;
    #4;
    dw = (d_a / 4) % 512;    db = (d_a / 2048) % 8;
    iw = (i_a / 4) % 512;    ib = (i_a / 2048) % 8;
    door = (db >= NB);       ioor = (ib >= NB);
    haz = d_r && d_w && i_r && !door && !ioor && db == ib && dw == iw;
    ig = i_r && !haz;
    last_ig = ig;
    check("d_gnt", dgnt, d_r);
    check("i_gnt", ignt, ig);
    e_csb0 = '1; e_web0 = '1; e_wm = '0; e_a0 = '0; e_din = '0; e_csb1 = '1; e_a1 = '0;
    if (d_r && !door) begin
      e_csb0[db] = 1'b0; e_web0[db] = !d_w; e_wm[db*NW +: NW] = d_be;
      e_a0[db*AW +: AW] = AW'(dw); e_din[db*DW +: DW] = d_wd;
    end
    if (ig && !ioor) begin
      e_csb1[ib] = 1'b0; e_a1[ib*AW +: AW] = AW'(iw);
    end
    check("csb0", csb0, e_csb0);   check("web0", web0, e_web0);
    check("wmask0", wmask0, e_wm); check("addr0", addr0, e_a0);
    check("din0", din0, e_din);    check("csb1", csb1, e_csb1);
    check("addr1", addr1, e_a1);
    check("clk0", clk0, {NB{clk}}); check("clk1", clk1, {NB{clk}});
    de = (dq.size() >= LAT) ? dq.pop_front() : '0;
    ie = (iq.size() >= LAT) ? iq.pop_front() : '0;
    check("d_rvalid", drvalid, de.v); check("d_err", derr, de.e);
    if (de.chk) check("d_rdata", drdata, de.d);
    check("i_rvalid", irvalid, ie.v); check("i_err", ierr, ie.e);
    if (ie.chk) check("i_rdata", irdata, ie.d);
    obs_dgnt = dgnt; obs_ignt = ignt; obs_csb0 = csb0; obs_csb1 = csb1; obs_web0 = web0;
    obs_a0 = addr0; obs_drv = drvalid; obs_drd = drdata; obs_derr = derr;
    obs_irv = irvalid; obs_ird = irdata; obs_ierr = ierr;
    dn.v = d_r; dn.e = d_r && door; dn.chk = d_r && (door || !d_w);
    dn.d = (d_r && !door) ? ref_rd(db, dw) : '0;
    inx.v = ig; inx.e = ig && ioor; inx.chk = ig;
    inx.d = (ig && !ioor) ? ref_rd(ib, iw) : '0;
    dq.push_back(dn); iq.push_back(inx);
    if (d_r && d_w && !door) begin
      old = ref_rd(db, dw);
      for (int l = 0; l < NW; l++) if (d_be[l]) old[l*8 +: 8] = d_wd[l*8 +: 8];
      ref_mem[db * 512 + dw] = old;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[10:2] = 9'($urandom_range(0, 7));
    a[13:11] = 3'($urandom_range(0, 7));
    return a;
  endfunction

  initial begin
    int rv_cnt;
    logic hold;
    logic d_r, d_w, i_r;
    logic [NW-1:0] d_be;
    logic [31:0] d_a, i_a, d_wd;
    // Reset held with an active dbus request
    rst_ni = 1'b0;
    dreq = 1'b1; dwe = 1'b1; dbe = '1; daddr = 32'h0000_0804; dwdata = 32'h1111_1111;
    ireq = 1'b1; iaddr = 32'h0000_0804; iwe = 1'b0; ibe = '0; iwdata = '0;
    #3 reset_checks("rst0");
    @(posedge clk); #4 reset_checks("rst1");
    @(posedge clk); #1;
    rst_ni = 1'b1;

    // Write then read back through dbus
    step(1'b1, 1'b1, 4'hF, 32'h0000_0804, 32'hDEAD_BEEF, 1'b0, '0);
    check("t2_csb0_b1", obs_csb0[1], 1'b0);
    check("t2_web0_b1", obs_web0[1], 1'b0);
    check("t2_addr0_b1", obs_a0[1*AW +: AW], 9'd1);
    step(1'b1, 1'b0, 4'hF, 32'h0000_0804, '0, 1'b0, '0);
    repeat (LAT) idle();
    check("t2_rvalid", obs_drv, 1'b1);
    check("t2_rdata", obs_drd, 32'hDEAD_BEEF);

    // Hazard: fetch of the word being written stalls one cycle
    step(1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678, 1'b1, 32'h0000_0010);
    check("t3_ignt_stall", obs_ignt, 1'b0);
    check("t3_csb1", obs_csb1, {NB{1'b1}});
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 32'h0000_0010);
    check("t3_ignt_retry", obs_ignt, 1'b1);
    repeat (LAT) idle();
    check("t3_irvalid", obs_irv, 1'b1);
    check("t3_irdata", obs_ird, 32'h1234_5678);

    // Concurrent accesses to different banks
    step(1'b1, 1'b0, 4'hF, 32'h0000_1000, '0, 1'b1, 32'h0000_2800);
    check("t4_dgnt", obs_dgnt, 1'b1);
    check("t4_ignt", obs_ignt, 1'b1);
    check("t4_csb0_b2", obs_csb0[2], 1'b0);
    check("t4_csb1_b5", obs_csb1[5], 1'b0);
    repeat (LAT) idle();
    check("t4_both_rvalid", {obs_drv, obs_irv}, 2'b11);

    // Out-of-range bank
    step(1'b1, 1'b0, 4'hF, 32'h0000_3000, '0, 1'b0, '0);
    check("t5_gnt", obs_dgnt, 1'b1);
    check("t5_no_csb", obs_csb0, {NB{1'b1}});
    repeat (LAT) idle();
    check("t5_rvalid", obs_drv, 1'b1);
    check("t5_err", obs_derr, 1'b1);
    check("t5_rdata", obs_drd, 32'h0);

    // Fetch stream interrupted by reset
    repeat (LAT) idle();
    rv_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      step(1'b0, 1'b0, '0, '0, '0, 1'b1, 32'h0000_1800 + 32'(4 * k));
      if (obs_irv) rv_cnt++;
    end
    check("t6_rvalid_count", 32'(rv_cnt), 32'(9 - LAT));
    #2 rst_ni = 1'b0;
    #2 reset_checks("t6_rst");
    dq.delete(); iq.delete();
    @(posedge clk); #1;
    rst_ni = 1'b1;
    repeat (4) idle();

    // Randomized traffic with hazard-prone address overlap
    hold = 1'b0; i_r = 1'b0; i_a = '0;
    for (int n = 0; n < 400; n++) begin
      d_r = ($urandom_range(0, 3) != 0);
      d_w = 1'($urandom);
      d_be = NW'($urandom);
      d_a = rand_addr();
      d_wd = $urandom;
      if (!hold) begin
        i_r = ($urandom_range(0, 2) != 0);
        i_a = rand_addr();
        if ($urandom_range(0, 2) == 0) i_a[13:2] = d_a[13:2];
      end
      step(d_r, d_w, d_be, d_a, d_wd, i_r, i_a);
      hold = i_r && !last_ig;
    end
    repeat (LAT) idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_bank_ctrl.md
Name: sram_bank_ctrl

Overview:
Parametrised multi-bank controller for OpenRAM-style dual-port SRAM macros (port 0 read/write, port 1 read-only) on the Ibex SoC memory bus.
- Serves two bus slaves: dbus (LSU) on port 0 of every bank, ibus (instruction fetch) on port 1 of every bank.
- Both masters access different banks, or the same bank, concurrently.
- Adds over the previous generation: NUM_BANKS generalisation, per-access chip select, read-during-write hazard stall, and out-of-range error response.

Parameters:
NUM_BANKS, 8, number of SRAM macros (1..16, need not be power of two)
NUM_WMASKS, 4, byte-enable lanes per word
DATA_WIDTH, 32, word width
ADDR_WIDTH, 9, word-address width per macro
BANK_BITS, $clog2(NUM_BANKS) (min 1), derived, not overridable

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
dbus  bus_if.slave  -  data bus (req, gnt, we, be, addr, wdata, rvalid, rdata, err)
ibus  bus_if.slave  -  instruction bus, same signals; we/be/wdata ignored
sram_clk0_o  output  NUM_BANKS  port-0 clocks (= clk_i)
sram_csb0_o  output  NUM_BANKS  port-0 active-low chip selects
sram_web0_o  output  NUM_BANKS  port-0 active-low write enables
sram_wmask0_o  output  NUM_BANKS*NUM_WMASKS  port-0 byte masks, bank b at [b*NUM_WMASKS +: NUM_WMASKS]
sram_addr0_o  output  NUM_BANKS*ADDR_WIDTH  port-0 word addresses
sram_din0_o  output  NUM_BANKS*DATA_WIDTH  port-0 write data
sram_dout0_i  input  NUM_BANKS*DATA_WIDTH  port-0 read data
sram_clk1_o  output  NUM_BANKS  port-1 clocks (= clk_i)
sram_csb1_o  output  NUM_BANKS  port-1 active-low chip selects
sram_addr1_o  output  NUM_BANKS*ADDR_WIDTH  port-1 word addresses
sram_dout1_i  input  NUM_BANKS*DATA_WIDTH  port-1 read data

Behaviour:
Address decode and errors
- Word = addr[ADDR_WIDTH+1:2]; bank = addr[ADDR_WIDTH+BANK_BITS+1:ADDR_WIDTH+2]; higher bits are ignored.
- bank >= NUM_BANKS means out of range. Such a request is granted, but no csb is asserted and no SRAM access happens.
- Next cycle the controller returns rvalid=1, err=1, rdata=0.

Port 0 (dbus)
- When granted with bank b: csb0[b]=0, web0[b]=!we, wmask0[b]=be, addr0[b]=word, din0[b]=wdata.
- Every non-selected bank: csb0=1, web0=1, wmask0=0, addr0=0, din0=0.

Port 1 (ibus)
- When granted with bank b: csb1[b]=0, addr1[b]=word.
- Every other bank: csb1=1, addr1=0.

Grant and hazard
- dbus.gnt = dbus.req, always; dbus is never stalled.
- ibus.gnt = ibus.req, except during a hazard.
- Hazard = dbus.req & dbus.we & ibus.req, both in range, same bank and same word.
- On a hazard, ibus.gnt=0 and csb1 stays high. The ibus master holds req; the fetch is granted on the first cycle without a hazard.

Response pipeline (per bus)
- Registers: rvalid_q <= req&gnt; bank_q <= bank; err_q <= out-of-range.
- Cycle after grant: rvalid=1; rdata = dout0[bank_q] for dbus, dout1[bank_q] for ibus; rdata=0 when err_q.
- rvalid also pulses for writes (rdata then don't-care, treated as 0).
- Back-to-back requests every cycle give one rvalid per cycle.

Other rules
- err=0 except in the error response cycle.
- Reset values: rvalid=0, err=0 and bank_q=0 for both buses. Combinational SRAM outputs idle at the values above.
- Reset asserted mid-transaction drops the outstanding response: no rvalid after reset release.
- Simultaneous dbus write and ibus read to the same bank but different words: both are granted in the same cycle.

Optional Feature:
SRAM_RDATA_REG_EN
- Defined: dout is captured into a per-bus output register. rvalid, rdata and err appear two cycles after the grant, with rvalid_q, bank_q and err_q pipelined one more stage.
- Full throughput is kept, and the hazard rule is unchanged.
- Undefined: one-cycle latency as above.

Test Plan:
1. Reset with rst_ni=0 while dbus.req=1 -> rvalid=0, err=0 on both buses; all csb0/csb1=1, all web0=1.
2. dbus write addr=0x0000_0804, wdata=0xDEADBEEF, be=0xF, then read same address -> cycle 0: csb0[1]=0, web0[1]=0, addr0[1]=1. Read cycle +1: rvalid=1, rdata=0xDEADBEEF.
3. dbus write 0x0000_0010 and ibus read 0x0000_0010 in the same cycle -> ibus.gnt=0 for one cycle. The fetch is granted next cycle; ibus.rvalid one cycle later returns the new data.
4. dbus read 0x0000_1000 (bank 2) and ibus read 0x0000_3800 (bank 7) in the same cycle -> both gnt=1, csb0[2]=0, csb1[7]=0; both rvalid next cycle with the correct data.
5. NUM_BANKS=6, dbus read 0x0000_3000 (bank 6) -> gnt=1, no csb asserted; next cycle rvalid=1, err=1, rdata=0.
6. Ibus streams 8 consecutive words, then reset is asserted mid-stream -> 8 rvalids with sequential data before reset; none after release until a new req.
